mesi_snoop_responder: RTL and testbench
=======================================

// Module: mesi_snoop_responder
// PURPOSE
//  Per-cache snoop responder: the listening end of the snoop bus. Holds a tag/MESI shadow directory of
//  its cache, decodes broadcast snoops, drives snoop_hit/snoop_supply/snoop_data_in back to snoop_bus,
//  fetches dirty lines from the cache data array and applies MESI snoop transitions. One per CPU.
// PARAMETERS
//  NUM_CPUS     4   CPUs on the snoop bus
//  CPU_ID       0   this cache's bus index; snoops with snoop_src==CPU_ID are ignored
//  ADDR_WIDTH   32  address width
//  CACHE_LINES  64  direct-mapped lines (power of 2)
//  LINE_SIZE    32  bytes per line; LINE_BITS=LINE_SIZE*8
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous, active-high reset
//  snoop_op       in   3           0 NONE,1 BUS_RD,2 BUS_RDX,3 BUS_UPGR,4 BUS_WB,5-7 treated as NONE
//  snoop_addr     in   ADDR_WIDTH  snooped address
//  snoop_src      in   $clog2(NUM_CPUS)  requesting CPU
//  snoop_busy     out  1           FSM not IDLE; bus must not issue a snoop while high
//  snoop_resp_valid out 1          one-cycle pulse qualifying hit/supply/data
//  snoop_hit      out  1           line present (state!=I, tag match)
//  snoop_supply   out  1           this cache supplies the line (was M)
//  snoop_data_in  out  LINE_BITS   supplied line, valid with supply
//  upd_valid      in   1           cache controller writes directory entry
//  upd_index      in   $clog2(CACHE_LINES)  entry index
//  upd_tag        in   TAG_WIDTH   tag, TAG_WIDTH=ADDR_WIDTH-log2(CACHE_LINES)-log2(LINE_SIZE)
//  upd_state      in   2           0 I,1 S,2 E,3 M
//  upd_ready      out  1           update accepted when upd_valid&upd_ready
//  dat_rd_req     out  1           request line from cache data array (held until dat_rd_valid)
//  dat_rd_index   out  $clog2(CACHE_LINES)  line to read
//  dat_rd_valid   in   1           data array returns line
//  dat_rd_data    in   LINE_BITS   line data
//  proto_err      out  1           sticky: BUS_UPGR hit a line in E or M
//  snoop_overrun  out  1           sticky: snoop_op!=NONE arrived while snoop_busy
// BEHAVIOUR
//  Reset: all directory states I, tags 0; FSM IDLE; every output 0 except upd_ready=1. Reset in any
//   state aborts the snoop (no response, no state write, dat_rd_req dropped).
//  Address split: offset=low log2(LINE_SIZE) bits, index=next log2(CACHE_LINES), tag=rest.
//  FSM IDLE: snoop_op in 1..4 and snoop_src!=CPU_ID -> capture op/index/tag, go LOOKUP. Own-source
//   or NONE: stay. upd_ready=1 only in IDLE with no snoop captured that cycle (snoop has priority).
//  LOOKUP (T+1): hit=(state!=I)&&(tag==cap_tag). Transitions, applied on the response cycle:
//   BUS_RD:  M->S supply; E->S, S->S hit only.
//   BUS_RDX: M->I supply; E,S->I hit only.
//   BUS_UPGR: S->I hit; E/M->I hit, set proto_err.
//   BUS_WB:  no state change; hit reported, never supply.
//   Miss: resp pulse hit=0,supply=0, no write. No-supply cases: resp pulse at T+1, back to IDLE.
//   Supply case: go DATA_WAIT, assert dat_rd_req/dat_rd_index from T+1.
//  DATA_WAIT: hold dat_rd_req until dat_rd_valid (same-cycle ok, no timeout); next cycle resp pulse
//   hit=1,supply=1,snoop_data_in=latched line; write new state; IDLE. Minimum supply latency T+2.
//  snoop_data_in is 0 whenever supply=0. snoop_busy=1 in LOOKUP/DATA_WAIT.
//  Snoop during busy: ignored, snoop_overrun set. Sticky flags clear only on reset.
//  upd writes tag+state in one cycle; visible to a snoop captured the following cycle.
// TESTING
//  1 Reset; BUS_RD src1 addr 0x0000_1000 -> resp at T+1 hit=0 supply=0; upd_ready=1.
//  2 upd idx2 tag2 M; BUS_RD src2 addr 0x0000_1040 -> dat_rd_req idx2; return 0xA5..A5 ->
//    resp hit=1 supply=1 data 0xA5..A5; follow-up BUS_RDX -> hit=1 supply=0; then BUS_RD -> hit=0.
//  3 upd idx2 tag2 E; BUS_RDX src3 0x1040 -> hit=1 supply=0 at T+1; upd_ready=0 that window.
//  4 snoop_src==CPU_ID on a valid M line -> no resp, no busy, state unchanged.
//  5 BUS_UPGR on M line -> hit=1, proto_err=1 sticky, line becomes I.
//  6 Supply snoop stalled in DATA_WAIT: second snoop -> snoop_overrun=1; assert rst -> all outputs 0, line I.

Source files
------------

// File: rtl/mesi_snoop_responder.sv
// Snoop responder for one cache: keeps a tag/MESI shadow directory, answers bus snoops,
// fetches dirty lines from the data array for supply and applies the MESI snoop transitions.
module mesi_snoop_responder #(
    parameter int NUM_CPUS    = 4,
    parameter int CPU_ID      = 0,
    parameter int ADDR_WIDTH  = 32,
    parameter int CACHE_LINES = 64,
    parameter int LINE_SIZE   = 32,
    localparam int SRC_BITS   = $clog2(NUM_CPUS),
    localparam int IDX_BITS   = $clog2(CACHE_LINES),
    localparam int OFF_BITS   = $clog2(LINE_SIZE),
    localparam int TAG_WIDTH  = ADDR_WIDTH - IDX_BITS - OFF_BITS,
    localparam int LINE_BITS  = LINE_SIZE * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            snoop_op,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    input  logic [SRC_BITS-1:0]   snoop_src,
    output logic                  snoop_busy,
    output logic                  snoop_resp_valid,
    output logic                  snoop_hit,
    output logic                  snoop_supply,
    output logic [LINE_BITS-1:0]  snoop_data_in,
    input  logic                  upd_valid,
    input  logic [IDX_BITS-1:0]   upd_index,
    input  logic [TAG_WIDTH-1:0]  upd_tag,
    input  logic [1:0]            upd_state,
    output logic                  upd_ready,
    output logic                  dat_rd_req,
    output logic [IDX_BITS-1:0]   dat_rd_index,
    input  logic                  dat_rd_valid,
    input  logic [LINE_BITS-1:0]  dat_rd_data,
    output logic                  proto_err,
    output logic                  snoop_overrun
);

    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_RDX  = 3'd2;
    localparam logic [2:0] OP_UPGR = 3'd3;
    localparam logic [2:0] OP_WB   = 3'd4;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_DATA_WAIT} state_t;

    state_t                 state;
    logic [TAG_WIDTH-1:0]   dir_tag   [CACHE_LINES];
    logic [1:0]             dir_state [CACHE_LINES];

    logic [IDX_BITS-1:0]    cap_idx;
    logic [1:0]             cap_new_state;
    logic                   cap_write;
    logic                   cap_supply;

    logic                   snoop_valid;
    logic                   snoop_accept;
    logic [IDX_BITS-1:0]    in_idx;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic [1:0]             cur_state;
    logic                   lookup_hit;
    logic [1:0]             lk_new_state;
    logic                   lk_write;
    logic                   lk_supply;
    logic                   lk_proto;
    logic                   unused_offset;

    assign snoop_valid   = (snoop_op >= OP_RD) && (snoop_op <= OP_WB);
    assign snoop_accept  = (state == ST_IDLE) && snoop_valid &&
                           (snoop_src != SRC_BITS'(CPU_ID));
    assign in_idx        = snoop_addr[OFF_BITS +: IDX_BITS];
    assign in_tag        = snoop_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign unused_offset = ^snoop_addr[OFF_BITS-1:0];
    assign cur_state     = dir_state[in_idx];
    assign lookup_hit    = (cur_state != MESI_I) && (dir_tag[in_idx] == in_tag);
    assign snoop_busy    = (state != ST_IDLE);

    // Directory update handshake: an entry is written on a cycle where upd_valid && upd_ready;
    // a snoop accepted in the same cycle wins and holds upd_ready low.
    assign upd_ready     = (state == ST_IDLE) && !snoop_accept;

    always_comb begin
        lk_new_state = cur_state;
        lk_write     = 1'b0;
        lk_supply    = 1'b0;
        lk_proto     = 1'b0;
        if (lookup_hit) begin
            case (snoop_op)
                OP_RD: begin
                    lk_new_state = MESI_S;
                    lk_write     = 1'b1;
                    lk_supply    = (cur_state == MESI_M);
                end
                OP_RDX: begin
                    lk_new_state = MESI_I;
                    lk_write     = 1'b1;
                    lk_supply    = (cur_state == MESI_M);
                end
                OP_UPGR: begin
                    lk_new_state = MESI_I;
                    lk_write     = 1'b1;
                    lk_proto     = (cur_state == MESI_E) || (cur_state == MESI_M);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CACHE_LINES; i++) begin
                dir_tag[i]   <= '0;
                dir_state[i] <= MESI_I;
            end
            state            <= ST_IDLE;
            cap_idx          <= '0;
            cap_new_state    <= MESI_I;
            cap_write        <= 1'b0;
            cap_supply       <= 1'b0;
            snoop_resp_valid <= 1'b0;
            snoop_hit        <= 1'b0;
            snoop_supply     <= 1'b0;
            snoop_data_in    <= '0;
            dat_rd_req       <= 1'b0;
            dat_rd_index     <= '0;
            proto_err        <= 1'b0;
            snoop_overrun    <= 1'b0;
        end else begin
            snoop_resp_valid <= 1'b0;
            snoop_hit        <= 1'b0;
            snoop_supply     <= 1'b0;
            snoop_data_in    <= '0;
            if ((state != ST_IDLE) && snoop_valid)
                snoop_overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (snoop_accept) begin
                        cap_idx       <= in_idx;
                        cap_new_state <= lk_new_state;
                        cap_write     <= lk_write;
                        cap_supply    <= lk_supply;
                        state         <= ST_LOOKUP;
                        if (lk_proto)
                            proto_err <= 1'b1;
                        // Non-supply answers go out during the lookup cycle itself.
                        if (lk_supply) begin
                            dat_rd_req   <= 1'b1;
                            dat_rd_index <= in_idx;
                        end else begin
                            snoop_resp_valid <= 1'b1;
                            snoop_hit        <= lookup_hit;
                        end
                    end else if (upd_valid) begin
                        dir_tag[upd_index]   <= upd_tag;
                        dir_state[upd_index] <= upd_state;
                    end
                end
                ST_LOOKUP, ST_DATA_WAIT: begin
                    if ((state == ST_LOOKUP) && !cap_supply) begin
                        if (cap_write)
                            dir_state[cap_idx] <= cap_new_state;
                        state <= ST_IDLE;
                    end else if (dat_rd_valid) begin
                        dat_rd_req         <= 1'b0;
                        snoop_resp_valid   <= 1'b1;
                        snoop_hit          <= 1'b1;
                        snoop_supply       <= 1'b1;
                        snoop_data_in      <= dat_rd_data;
                        dir_state[cap_idx] <= cap_new_state;
                        state              <= ST_IDLE;
                    end else begin
                        state <= ST_DATA_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Bench for mesi_snoop_responder: directed corner-case sequences followed by a table of
// directory-state/snoop-op vectors; responses are checked against an expected queue.
module tb_mesi_snoop_responder;

    localparam int LINE_BITS = 256;
    localparam int RW        = LINE_BITS + 2;

    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_RDX  = 3'd2;
    localparam logic [2:0] OP_UPGR = 3'd3;
    localparam logic [2:0] OP_WB   = 3'd4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [2:0]           snoop_op = '0;
    logic [31:0]          snoop_addr = '0;
    logic [1:0]           snoop_src = '0;
    logic                 snoop_busy;
    logic                 snoop_resp_valid;
    logic                 snoop_hit;
    logic                 snoop_supply;
    logic [LINE_BITS-1:0] snoop_data_in;
    logic                 upd_valid = 1'b0;
    logic [5:0]           upd_index = '0;
    logic [20:0]          upd_tag = '0;
    logic [1:0]           upd_state = '0;
    logic                 upd_ready;
    logic                 dat_rd_req;
    logic [5:0]           dat_rd_index;
    logic                 dat_rd_valid = 1'b0;
    logic [LINE_BITS-1:0] dat_rd_data = '0;
    logic                 proto_err;
    logic                 snoop_overrun;

    mesi_snoop_responder dut (
        .clk(clk), .rst(rst),
        .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
        .snoop_busy(snoop_busy), .snoop_resp_valid(snoop_resp_valid),
        .snoop_hit(snoop_hit), .snoop_supply(snoop_supply), .snoop_data_in(snoop_data_in),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_tag(upd_tag),
        .upd_state(upd_state), .upd_ready(upd_ready),
        .dat_rd_req(dat_rd_req), .dat_rd_index(dat_rd_index),
        .dat_rd_valid(dat_rd_valid), .dat_rd_data(dat_rd_data),
        .proto_err(proto_err), .snoop_overrun(snoop_overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_r;
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && snoop_resp_valid) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected: got hit=%0b supply=%0b, required no response",
                         snoop_hit, snoop_supply);
            end else begin
                exp_r = exp_q.pop_front();
                if ({snoop_hit, snoop_supply, snoop_data_in} === exp_r) n_pass++;
                else $display("FAIL resp: got hit=%0b supply=%0b data=%h, required hit=%0b supply=%0b data=%h",
                              snoop_hit, snoop_supply, snoop_data_in,
                              exp_r[RW-1], exp_r[RW-2], exp_r[LINE_BITS-1:0]);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_addr(input logic [20:0] tag, input logic [5:0] idx,
                                              input logic [4:0] off);
        return {tag, idx, off};
    endfunction

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_upd(input logic [5:0] idx, input logic [20:0] tag, input logic [1:0] st);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_tag   = tag;
        upd_state = st;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 10 && snoop_busy; n++) tick();
        chk("busy_clear", snoop_busy, 1'b0);
    endtask

    task automatic do_snoop(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] src,
                            input logic eh, input logic es, input logic [LINE_BITS-1:0] line,
                            input int delay);
        exp_q.push_back({eh, es, es ? line : {LINE_BITS{1'b0}}});
        snoop_op   = op;
        snoop_addr = addr;
        snoop_src  = src;
        tick();
        snoop_op = 3'd0;
        if (!es) begin
            chk("resp_at_t1", snoop_resp_valid, 1'b1);
        end else begin
            chk("rd_req", dat_rd_req, 1'b1);
            chk("rd_index", dat_rd_index, addr[10:5]);
            repeat (delay) tick();
            dat_rd_valid = 1'b1;
            dat_rd_data  = line;
            tick();
            dat_rd_valid = 1'b0;
            dat_rd_data  = '0;
            chk("resp_supply", snoop_resp_valid, 1'b1);
            chk("rd_req_drop", dat_rd_req, 1'b0);
        end
        wait_idle();
    endtask

    typedef struct {
        logic [1:0] init_state;
        logic       tag_match;
        logic [2:0] op;
        logic       exp_hit;
        logic       exp_supply;
        logic       exp_valid_after;
        logic       exp_proto;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [LINE_BITS-1:0] a5;
        logic [31:0] addr;
        logic [20:0] tag;
        logic proto_acc;

        a5 = {32{8'hA5}};

        // reset values, then a miss on an empty directory
        do_reset();
        chk("rst_resp_valid", snoop_resp_valid, 1'b0);
        chk("rst_busy", snoop_busy, 1'b0);
        chk("rst_rd_req", dat_rd_req, 1'b0);
        chk("rst_proto", proto_err, 1'b0);
        chk("rst_overrun", snoop_overrun, 1'b0);
        chk("rst_upd_ready", upd_ready, 1'b1);
        do_snoop(OP_RD, 32'h0000_1000, 2'd1, 1'b0, 1'b0, '0, 0);
        chk("upd_ready_idle", upd_ready, 1'b1);

        // supply from M, then M->S, then S->I
        do_upd(6'd2, 21'd2, 2'd3);
        do_snoop(OP_RD, 32'h0000_1040, 2'd2, 1'b1, 1'b1, a5, 1);
        do_snoop(OP_RDX, 32'h0000_1040, 2'd1, 1'b1, 1'b0, '0, 0);
        do_snoop(OP_RD, 32'h0000_1040, 2'd1, 1'b0, 1'b0, '0, 0);

        // snoop beats a simultaneous update; upd_ready low through the window
        do_upd(6'd2, 21'd2, 2'd2);
        upd_valid  = 1'b1;
        upd_index  = 6'd3;
        upd_tag    = 21'd2;
        upd_state  = 2'd3;
        snoop_op   = OP_RDX;
        snoop_addr = 32'h0000_1040;
        snoop_src  = 2'd3;
        #1;
        chk("upd_ready_snoop_prio", upd_ready, 1'b0);
        exp_q.push_back({1'b1, 1'b0, {LINE_BITS{1'b0}}});
        tick();
        snoop_op  = 3'd0;
        chk("rdx_e_resp_t1", snoop_resp_valid, 1'b1);
        chk("upd_ready_lookup", upd_ready, 1'b0);
        upd_valid = 1'b0;
        wait_idle();
        do_snoop(OP_WB, 32'h0000_1060, 2'd1, 1'b0, 1'b0, '0, 0);
        do_snoop(OP_WB, 32'h0000_1040, 2'd1, 1'b0, 1'b0, '0, 0);

        // own-source snoop is ignored
        do_upd(6'd4, 21'd2, 2'd3);
        snoop_op   = OP_RD;
        snoop_addr = 32'h0000_1080;
        snoop_src  = 2'd0;
        tick();
        snoop_op = 3'd0;
        chk("own_src_busy", snoop_busy, 1'b0);
        chk("own_src_resp", snoop_resp_valid, 1'b0);
        chk("own_src_rd_req", dat_rd_req, 1'b0);
        do_snoop(OP_WB, 32'h0000_1080, 2'd1, 1'b1, 1'b0, '0, 0);
        do_snoop(OP_RD, 32'h0000_1080, 2'd3, 1'b1, 1'b1, rand_line(), 0);

        // BUS_UPGR on M: protocol error, line invalidated
        do_upd(6'd6, 21'd2, 2'd3);
        chk("proto_before", proto_err, 1'b0);
        do_snoop(OP_UPGR, 32'h0000_10C0, 2'd2, 1'b1, 1'b0, '0, 0);
        chk("proto_set", proto_err, 1'b1);
        do_snoop(OP_WB, 32'h0000_10C0, 2'd1, 1'b0, 1'b0, '0, 0);
        chk("proto_sticky", proto_err, 1'b1);

        // stalled supply, overrun, then reset mid-snoop
        do_upd(6'd5, 21'd2, 2'd3);
        snoop_op   = OP_RD;
        snoop_addr = 32'h0000_10A0;
        snoop_src  = 2'd1;
        tick();
        snoop_op = 3'd0;
        chk("stall_rd_req", dat_rd_req, 1'b1);
        tick();
        chk("stall_busy", snoop_busy, 1'b1);
        chk("overrun_before", snoop_overrun, 1'b0);
        snoop_op   = OP_RD;
        snoop_addr = 32'h0000_1000;
        snoop_src  = 2'd2;
        tick();
        snoop_op = 3'd0;
        chk("overrun_set", snoop_overrun, 1'b1);
        chk("stall_rd_req_held", dat_rd_req, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort_resp", snoop_resp_valid, 1'b0);
        chk("abort_busy", snoop_busy, 1'b0);
        chk("abort_rd_req", dat_rd_req, 1'b0);
        chk("abort_proto", proto_err, 1'b0);
        chk("abort_overrun", snoop_overrun, 1'b0);
        chk("abort_upd_ready", upd_ready, 1'b1);
        rst = 1'b0;
        tick();
        do_snoop(OP_WB, 32'h0000_10A0, 2'd1, 1'b0, 1'b0, '0, 0);

        // state x op table: init, match, op, hit, supply, valid after, proto
        vecs[0]  = '{2'd3, 1'b1, OP_RD,   1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{2'd2, 1'b1, OP_RD,   1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{2'd1, 1'b1, OP_RD,   1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 1'b1, OP_RD,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'd3, 1'b0, OP_RD,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'd3, 1'b1, OP_RDX,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'd2, 1'b1, OP_RDX,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'd1, 1'b1, OP_RDX,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'd1, 1'b1, OP_UPGR, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'd3, 1'b1, OP_WB,   1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'd2, 1'b1, OP_WB,   1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'd0, 1'b1, OP_RDX,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'd2, 1'b1, OP_UPGR, 1'b1, 1'b0, 1'b0, 1'b1};

        proto_acc = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tag  = 21'($urandom);
            addr = make_addr(tag, 6'(i + 8), 5'($urandom_range(0, 31)));
            do_upd(6'(i + 8), vecs[i].tag_match ? tag : (tag ^ 21'd1), vecs[i].init_state);
            do_snoop(vecs[i].op, addr, 2'($urandom_range(1, 3)), vecs[i].exp_hit,
                     vecs[i].exp_supply, rand_line(), $urandom_range(0, 3));
            do_snoop(OP_WB, addr, 2'($urandom_range(1, 3)), vecs[i].exp_valid_after,
                     1'b0, '0, 0);
            proto_acc = proto_acc | vecs[i].exp_proto;
            chk("vec_proto", proto_err, proto_acc);
        end

        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
